// File: rtl/ac_motor_gate_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ac_motor_gate_monitor_pkg
// Shared definitions for the gate-drive monitor: per-phase FSM state
// encoding, latched fault-code values and default parameter values.
// ---------------------------------------------------------------------------
package ac_motor_gate_monitor_pkg;

  localparam int unsigned DELAY_W_DEF = 11;
  localparam int unsigned TOL_DEF     = 2;
  localparam int unsigned PHASES_DEF  = 3;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_HIGH_ON = 3'd1,
    ST_LOW_ON  = 3'd2,
    ST_DEAD_HL = 3'd3,
    ST_DEAD_LH = 3'd4
  } phase_state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_DEAD  = 2'b01;
  localparam logic [1:0] FC_SHORT = 2'b10;

endpackage

// File: rtl/ac_motor_gate_monitor_if.sv
// ---------------------------------------------------------------------------
// ac_motor_gate_monitor_if
// Bundles the control/gate inputs and status outputs of the monitor.
//   master : control side (drives enable, delay, gates, fault_clr)
//   slave  : monitor side (drives gate_enable, s_decoded, fault,
//            fault_code, dead_meas)
// ---------------------------------------------------------------------------
interface ac_motor_gate_monitor_if #(
  parameter int unsigned DELAY_W = ac_motor_gate_monitor_pkg::DELAY_W_DEF
);
  logic                 enable;
  logic [DELAY_W-1:0]   delay;
  logic [2:0]           s_high;
  logic [2:0]           s_low;
  logic                 fault_clr;
  logic                 gate_enable;
  logic [2:0]           s_decoded;
  logic                 fault;
  logic [5:0]           fault_code;
  logic [3*DELAY_W-1:0] dead_meas;

  modport master (
    output enable, delay, s_high, s_low, fault_clr,
    input  gate_enable, s_decoded, fault, fault_code, dead_meas
  );

  modport slave (
    input  enable, delay, s_high, s_low, fault_clr,
    output gate_enable, s_decoded, fault, fault_code, dead_meas
  );
endinterface

// File: rtl/ac_motor_gate_phase_check.sv
// ---------------------------------------------------------------------------
// ac_motor_gate_phase_check
// One phase of the gate monitor: registers the gate pair, tracks the
// switch state, measures dead time at each commutation and latches the
// first fault seen on this phase.
//   clk, rst     : clock, async active-high reset
//   i_enable     : enables the dead-time check
//   i_delay      : programmed dead time (cycles)
//   i_high/i_low : raw gate pair for this phase
//   i_clr        : qualified fault clear from the top level
//   o_dec        : reconstructed switch state
//   o_idle       : registered gates both off
//   o_new_fault  : a fault is detected this cycle
//   o_code       : latched fault code
//   o_dead_meas  : last measured dead time
// ---------------------------------------------------------------------------
module ac_motor_gate_phase_check
  import ac_motor_gate_monitor_pkg::*;
#(
  parameter int unsigned DELAY_W = DELAY_W_DEF,
  parameter int unsigned TOL     = TOL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic               i_high,
  input  logic               i_low,
  input  logic               i_clr,
  output logic               o_dec,
  output logic               o_idle,
  output logic               o_new_fault,
  output logic [1:0]         o_code,
  output logic [DELAY_W-1:0] o_dead_meas
);

  localparam logic [DELAY_W-1:0] CNT_MAX = '1;
  localparam logic [DELAY_W-1:0] TOL_V   = DELAY_W'(TOL);

  logic               r_high, r_low;
  phase_state_t       r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
  logic [DELAY_W-1:0] r_meas, w_meas_val;
  logic [DELAY_W-1:0] w_thr;
  logic               w_meas_en, w_check, w_shoot, w_dead_viol;
  logic [1:0]         r_code, w_code_new;
  logic               r_dec, w_dec_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high <= 1'b0;
      r_low  <= 1'b0;
    end else begin
      r_high <= i_high;
      r_low  <= i_low;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_OFF;
    else     r_state <= w_state_nxt;
  end

  // delay is used live, so a mid-interval change applies at the compare
  assign w_thr = (i_delay > TOL_V) ? (i_delay - TOL_V) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_meas_en   = 1'b0;
    w_meas_val  = r_cnt;
    w_check     = 1'b0;
    w_shoot     = 1'b0;
    if (r_high && r_low) begin
      // parking in OFF while both are on means the phase restarts from OFF
      // once the short clears, with no dead-time check on that edge
      w_shoot     = 1'b1;
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (r_high)     w_state_nxt = ST_HIGH_ON;
          else if (r_low) w_state_nxt = ST_LOW_ON;
        end
        ST_HIGH_ON: begin
          if (!r_high) begin
            if (r_low) begin
              w_state_nxt = ST_LOW_ON;
              w_meas_en   = 1'b1;
              w_meas_val  = '0;
              w_check     = 1'b1;
            end else begin
              w_state_nxt = ST_DEAD_HL;
              w_cnt_nxt   = DELAY_W'(1);
            end
          end
        end
        ST_LOW_ON: begin
          if (!r_low) begin
            if (r_high) begin
              w_state_nxt = ST_HIGH_ON;
              w_meas_en   = 1'b1;
              w_meas_val  = '0;
              w_check     = 1'b1;
            end else begin
              w_state_nxt = ST_DEAD_LH;
              w_cnt_nxt   = DELAY_W'(1);
            end
          end
        end
        ST_DEAD_HL: begin
          if (r_low) begin
            w_state_nxt = ST_LOW_ON;
            w_meas_en   = 1'b1;
            w_check     = 1'b1;
          end else if (r_high) begin
            w_state_nxt = ST_HIGH_ON;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_DEAD_LH: begin
          if (r_high) begin
            w_state_nxt = ST_HIGH_ON;
            w_meas_en   = 1'b1;
            w_check     = 1'b1;
          end else if (r_low) begin
            w_state_nxt = ST_LOW_ON;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = ST_OFF;
      endcase
    end
  end

  assign w_dead_viol = w_check && i_enable && (w_meas_val < w_thr);

  always_comb begin
    w_code_new = FC_NONE;
    if (w_shoot)          w_code_new = FC_SHORT;
    else if (w_dead_viol) w_code_new = FC_DEAD;
  end

  always_comb begin
    w_dec_nxt = r_dec;
    case (w_state_nxt)
      ST_HIGH_ON:        w_dec_nxt = 1'b1;
      ST_LOW_ON, ST_OFF: w_dec_nxt = 1'b0;
      default:           w_dec_nxt = r_dec;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_meas <= '0;
      r_code <= FC_NONE;
      r_dec  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dec <= w_dec_nxt;
      if (w_meas_en) r_meas <= w_meas_val;
      // first fault wins; the top never asserts i_clr alongside a new fault
      if ((r_code == FC_NONE) && (w_code_new != FC_NONE)) r_code <= w_code_new;
      else if (i_clr)                                     r_code <= FC_NONE;
    end
  end

  assign o_dec       = r_dec;
  assign o_idle      = ~r_high & ~r_low;
  assign o_new_fault = w_shoot | w_dead_viol;
  assign o_code      = r_code;
  assign o_dead_meas = r_meas;

endmodule

// File: rtl/ac_motor_gate_monitor.sv
// ---------------------------------------------------------------------------
// ac_motor_gate_monitor
// Receiving end of the dead-time gate-drive interface. Decodes each phase's
// gate pair, measures inserted dead time, latches shoot-through and
// dead-time faults, and produces gate_enable for the switch-delay stage.
//   clk, rst : clock, async active-high reset
//   bus      : slave modport of ac_motor_gate_monitor_if (control inputs,
//              gate pairs, fault_clr in; gate_enable, s_decoded, fault,
//              fault_code, dead_meas out)
// ---------------------------------------------------------------------------
module ac_motor_gate_monitor
  import ac_motor_gate_monitor_pkg::*;
#(
  parameter int unsigned DELAY_W = DELAY_W_DEF,
  parameter int unsigned TOL     = TOL_DEF,
  parameter int unsigned PHASES  = PHASES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  ac_motor_gate_monitor_if.slave  bus
);

  logic [PHASES-1:0]         w_dec, w_idle, w_new;
  logic [1:0]                w_code [PHASES];
  logic [DELAY_W-1:0]        w_meas [PHASES];
  logic [2*PHASES-1:0]       w_code_flat;
  logic [PHASES*DELAY_W-1:0] w_meas_flat;
  logic                      w_any_code, w_clr_ok, w_fault_nxt;
  logic                      r_gate_en;

  for (genvar p = 0; p < PHASES; p++) begin : g_phase
    ac_motor_gate_phase_check #(
      .DELAY_W (DELAY_W),
      .TOL     (TOL)
    ) u_phase (
      .clk         (clk),
      .rst         (rst),
      .i_enable    (bus.enable),
      .i_delay     (bus.delay),
      .i_high      (bus.s_high[p]),
      .i_low       (bus.s_low[p]),
      .i_clr       (w_clr_ok),
      .o_dec       (w_dec[p]),
      .o_idle      (w_idle[p]),
      .o_new_fault (w_new[p]),
      .o_code      (w_code[p]),
      .o_dead_meas (w_meas[p])
    );
  end

  always_comb begin
    w_code_flat = '0;
    w_meas_flat = '0;
    w_any_code  = 1'b0;
    for (int unsigned p = 0; p < PHASES; p++) begin
      w_code_flat[2*p +: 2]             = w_code[p];
      w_meas_flat[p*DELAY_W +: DELAY_W] = w_meas[p];
      w_any_code                        = w_any_code | (w_code[p] != FC_NONE);
    end
  end

  assign w_clr_ok    = bus.fault_clr & (&w_idle) & ~(|w_new);
  // fault state as it will stand after this edge's latch/clear
  assign w_fault_nxt = ~w_clr_ok & (w_any_code | (|w_new));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_gate_en <= 1'b0;
    else     r_gate_en <= bus.enable & ~w_fault_nxt;
  end

  assign bus.gate_enable = r_gate_en;
  assign bus.s_decoded   = w_dec;
  assign bus.fault       = w_any_code;
  assign bus.fault_code  = w_code_flat;
  assign bus.dead_meas   = w_meas_flat;

endmodule

// File: tb/tb_ac_motor_gate_monitor.sv
// ---------------------------------------------------------------------------
// tb_ac_motor_gate_monitor
// Table of single-phase commutations plus hand sequences for shoot-through,
// fault clearing, glitch and counter saturation. Expected outputs are queued
// with the cycle they are due and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_ac_motor_gate_monitor;

  localparam int unsigned DW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ac_motor_gate_monitor_if #(.DELAY_W(DW)) bus ();

  ac_motor_gate_monitor #(
    .DELAY_W (DW),
    .TOL     (2),
    .PHASES  (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int unsigned ph;
    int unsigned nd;
    logic        en;
    logic [DW-1:0] dly;
    logic [1:0]  code;
  } vec_t;

  typedef struct {
    int unsigned   due;
    string         nm;
    logic [5:0]    code;
    logic          fault;
    logic          ge;
    logic          chk_dec;
    logic [2:0]    dec;
    logic          chk_meas;
    int unsigned   ph;
    logic [DW-1:0] meas;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  exp_t me;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      cmp({me.nm, "_due"}, me.due, cyc);
      cmp({me.nm, "_code"}, 32'(bus.fault_code), 32'(me.code));
      cmp({me.nm, "_fault"}, 32'(bus.fault), 32'(me.fault));
      cmp({me.nm, "_gate_en"}, 32'(bus.gate_enable), 32'(me.ge));
      if (me.chk_dec)  cmp({me.nm, "_dec"}, 32'(bus.s_decoded), 32'(me.dec));
      if (me.chk_meas) cmp({me.nm, "_meas"}, 32'(bus.dead_meas[me.ph*DW +: DW]), 32'(me.meas));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setg(input logic [2:0] hi, input logic [2:0] lo, input logic clr);
    bus.s_high    = hi;
    bus.s_low     = lo;
    bus.fault_clr = clr;
  endtask

  task automatic push_exp(input int unsigned lag, input string nm, input logic [5:0] code,
                          input logic ge, input logic chk_dec, input logic [2:0] dec,
                          input logic chk_meas, input int unsigned ph, input logic [DW-1:0] meas);
    exp_t e;
    e.due = cyc + lag;  e.nm = nm;   e.code = code; e.fault = |code;
    e.ge  = ge;         e.chk_dec = chk_dec;  e.dec = dec;
    e.chk_meas = chk_meas; e.ph = ph; e.meas = meas;
    sb.push_back(e);
  endtask

  task automatic cleanup(input logic en, input logic [DW-1:0] dly);
    bus.enable = en;
    bus.delay  = dly;
    setg(3'b000, 3'b000, 1'b0);
    repeat (2) tick();
    setg(3'b000, 3'b000, 1'b1);
    tick();
    setg(3'b000, 3'b000, 1'b0);
    repeat (10) tick();
  endtask

  localparam int unsigned NV = 10;
  vec_t       vt [NV];
  logic [2:0] hi;
  logic [5:0] ec;

  initial begin
    vt[0] = '{0, 12, 1'b1, 11'd10, 2'b00};
    vt[1] = '{0,  7, 1'b1, 11'd10, 2'b01};
    vt[2] = '{0,  8, 1'b1, 11'd10, 2'b00};
    vt[3] = '{0,  3, 1'b0, 11'd10, 2'b00};
    vt[4] = '{0,  3, 1'b1, 11'd10, 2'b01};
    vt[5] = '{1,  9, 1'b1, 11'd10, 2'b00};
    vt[6] = '{2,  0, 1'b1, 11'd1,  2'b00};
    vt[7] = '{2,  0, 1'b1, 11'd3,  2'b01};
    vt[8] = '{1,  2, 1'b1, 11'd4,  2'b00};
    vt[9] = '{2,  1, 1'b1, 11'd4,  2'b01};

    rst = 1'b1;
    bus.enable = 1'b1;
    bus.delay  = 11'd10;
    setg(3'b000, 3'b000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_gate_en", 32'(bus.gate_enable), 32'd0);
    cmp("rst_dec",     32'(bus.s_decoded),   32'd0);
    cmp("rst_fault",   32'(bus.fault),       32'd0);
    cmp("rst_code",    32'(bus.fault_code),  32'd0);
    cmp("rst_meas",    32'(bus.dead_meas),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // single-phase commutations: high, dead interval, low
    for (int unsigned v = 0; v < NV; v++) begin
      cleanup(vt[v].en, vt[v].dly);
      hi = 3'b001 << vt[v].ph;
      setg(hi, 3'b000, 1'b0);
      push_exp(2, "vec_high", 6'b0, vt[v].en, 1'b1, hi, 1'b0, 0, '0);
      repeat (3) tick();
      for (int unsigned i = 0; i < vt[v].nd; i++) begin
        setg(3'b000, 3'b000, 1'b0);
        if (i == vt[v].nd - 1) push_exp(2, "vec_dead_hold", 6'b0, vt[v].en, 1'b1, hi, 1'b0, 0, '0);
        tick();
      end
      setg(3'b000, hi, 1'b0);
      ec = {4'b0, vt[v].code} << (2 * vt[v].ph);
      push_exp(2, "vec_low", ec, vt[v].en & ~(|ec), 1'b1, 3'b000, 1'b1, vt[v].ph, DW'(vt[v].nd));
      repeat (3) tick();
    end

    // phase 2 shoot-through while phase 1 has a 1-cycle dead time
    cleanup(1'b1, 11'd10);
    setg(3'b011, 3'b000, 1'b0);
    repeat (3) tick();
    setg(3'b010, 3'b000, 1'b0);
    tick();
    setg(3'b010, 3'b011, 1'b0);
    push_exp(2, "shoot_and_dead", 6'b001001, 1'b0, 1'b1, 3'b000, 1'b1, 0, 11'd1);
    tick();
    setg(3'b000, 3'b001, 1'b0);
    tick();

    // clear blocked while phase 3 low is on
    setg(3'b000, 3'b100, 1'b0);
    repeat (2) tick();
    setg(3'b000, 3'b100, 1'b1);
    push_exp(1, "clr_blocked", 6'b001001, 1'b0, 1'b0, 3'b000, 1'b0, 0, '0);
    tick();
    // later shoot-through on phase 1 keeps the first code
    setg(3'b001, 3'b101, 1'b0);
    push_exp(2, "first_wins", 6'b001001, 1'b0, 1'b0, 3'b000, 1'b0, 0, '0);
    tick();
    setg(3'b000, 3'b000, 1'b0);
    repeat (2) tick();
    setg(3'b000, 3'b000, 1'b1);
    push_exp(1, "clr_ok", 6'b000000, 1'b1, 1'b1, 3'b000, 1'b0, 0, '0);
    tick();
    setg(3'b000, 3'b000, 1'b0);
    tick();

    // glitch: high -> dead 4 -> high leaves dead_meas alone
    cleanup(1'b1, 11'd10);
    setg(3'b000, 3'b001, 1'b0);
    repeat (3) tick();
    setg(3'b000, 3'b000, 1'b0);
    repeat (10) tick();
    setg(3'b001, 3'b000, 1'b0);
    push_exp(2, "pre_glitch", 6'b0, 1'b1, 1'b1, 3'b001, 1'b1, 0, 11'd10);
    repeat (3) tick();
    for (int unsigned i = 0; i < 4; i++) begin
      setg(3'b000, 3'b000, 1'b0);
      if (i == 3) push_exp(2, "glitch_hold", 6'b0, 1'b1, 1'b1, 3'b001, 1'b1, 0, 11'd10);
      tick();
    end
    setg(3'b001, 3'b000, 1'b0);
    push_exp(2, "glitch_back", 6'b0, 1'b1, 1'b1, 3'b001, 1'b1, 0, 11'd10);
    repeat (3) tick();

    // saturation of the dead-time counter
    setg(3'b000, 3'b000, 1'b0);
    repeat (3000) tick();
    setg(3'b000, 3'b001, 1'b0);
    push_exp(2, "saturate", 6'b0, 1'b1, 1'b1, 3'b000, 1'b1, 0, 11'd2047);
    repeat (3) tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
